// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x 32-bit general-purpose register file for the decode stage.
// Two combinational read ports with write-through bypass, one synchronous
// writeback port, and a scoreboard of pending-write bits set at issue.
// Register 0 is hardwired to zero and never becomes pending.

module reg_file_sb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  // Read ports
  input  logic [4:0]       raddr_a,
  input  logic [4:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rdy_a,
  output logic             rdy_b,

  // Writeback port
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,

  // Issue port: marks the destination as having an outstanding producer
  input  logic             iss,
  input  logic [4:0]       iss_dst
);

  // Storage. Entry 0 is never written, so it stays at its reset value of 0
  // and is optimised away; reads of address 0 are forced to 0 regardless.
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  logic wr_en;
  logic iss_en;

  assign wr_en  = we  & (waddr   != 5'd0);
  assign iss_en = iss & (iss_dst != 5'd0);

  // Next state: writeback updates data and clears pending; issue sets pending
  // afterwards so a same-register collision leaves the entry pending.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
      pend_d[waddr] = 1'b0;
    end
    if (iss_en) begin
      pend_d[iss_dst] = 1'b1;
    end
  end

  // State registers with asynchronous clear of all data and pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  // Read port A: zero register, then same-cycle write bypass, then storage.
  always_comb begin
    rdata_a = '0;
    rdy_a   = 1'b1;
    if (raddr_a != 5'd0) begin
      if (we && (waddr == raddr_a)) begin
        rdata_a = wdata;
      end else begin
        rdata_a = regs_q[raddr_a];
        rdy_a   = ~pend_q[raddr_a];
      end
    end
  end

  // Read port B: identical to port A, fully independent.
  always_comb begin
    rdata_b = '0;
    rdy_b   = 1'b1;
    if (raddr_b != 5'd0) begin
      if (we && (waddr == raddr_b)) begin
        rdata_b = wdata;
      end else begin
        rdata_b = regs_q[raddr_b];
        rdy_b   = ~pend_q[raddr_b];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by random
// traffic, checked against a simple array model of the register file.

module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        rdy_a;
  logic        rdy_b;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss;
  logic [4:0]  iss_dst;

  int n_vec;
  int n_err;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_pend [32];

  reg_file_sb #(
    .WIDTH(32),
    .DEPTH(32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .rdy_a   (rdy_a),
    .rdy_b   (rdy_b),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .iss     (iss),
    .iss_dst (iss_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Expected read result from the current model and live write inputs.
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_rdy(input logic [4:0] a);
    if (a == 5'd0) return 1'b1;
    if (we && waddr == a) return 1'b1;
    return !m_pend[a];
  endfunction

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic i, input logic [4:0] id,
                       input logic [4:0] ra, input logic [4:0] rb);
    we = w; waddr = wa; wdata = wd; iss = i; iss_dst = id;
    raddr_a = ra; raddr_b = rb;
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, ".rdata_a"}, rdata_a, exp_data(raddr_a));
    check({tag, ".rdy_a"},   {31'b0, rdy_a}, {31'b0, exp_rdy(raddr_a)});
    check({tag, ".rdata_b"}, rdata_b, exp_data(raddr_b));
    check({tag, ".rdy_b"},   {31'b0, rdy_b}, {31'b0, exp_rdy(raddr_b)});
  endtask

  // One clock: model applies the writeback and issue rules at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (we && waddr != 5'd0) begin
        m_regs[waddr] = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (iss && iss_dst != 5'd0) m_pend[iss_dst] = 1'b1;
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_ports("reset_state");

    // Reset and zero register
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    #1 check("pre_reset_r5", rdata_a, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    model_clear();
    #1 check("async_reset_r5", rdata_a, 32'h0);
    check("async_reset_rdy", {31'b0, rdy_a}, 32'h1);
    tick();
    // Live bypass during reset; the edge must not store it.
    drive(1'b1, 5'd8, 32'hAAAA5555, 1'b0, 5'd0, 5'd5, 5'd8);
    check_ports("reset_bypass");
    tick();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd8);
    #1 check("reset_blocks_write", rdata_b, 32'h0);
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("r0_write_same_cycle", rdata_a, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("r0_read", rdata_a, 32'h0);
    check("r0_rdy", {31'b0, rdy_a}, 32'h1);

    // Write then read
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd31, 32'h0000FFFF, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd31);
    #1 check("rd_a_r7", rdata_a, 32'hA5A5A5A5);
    check("rd_b_r31", rdata_b, 32'h0000FFFF);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1 check("both_r7_a", rdata_a, 32'hA5A5A5A5);
    check("both_r7_b", rdata_b, 32'hA5A5A5A5);

    // Bypass
    drive(1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'h22222222, 1'b0, 5'd0, 5'd9, 5'd0);
    #1 check("bypass_r9", rdata_a, 32'h22222222);
    tick();

    // Scoreboard set and clear
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd0);
    #1 check("sb_n_rdy", {31'b0, rdy_a}, 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
    #1 check("sb_n1_rdy", {31'b0, rdy_a}, 32'h0);
    tick();
    #1 check("sb_n2_rdy", {31'b0, rdy_a}, 32'h0);
    tick();
    drive(1'b1, 5'd12, 32'hCAFE0012, 1'b0, 5'd0, 5'd12, 5'd0);
    #1 check("sb_n3_rdy", {31'b0, rdy_a}, 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
    #1 check("sb_n4_rdy", {31'b0, rdy_a}, 32'h1);

    // Write/issue collision
    drive(1'b1, 5'd4, 32'h77, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
    #1 check("coll_data", rdata_a, 32'h77);
    check("coll_rdy", {31'b0, rdy_a}, 32'h0);
    drive(1'b1, 5'd4, 32'h88, 1'b1, 5'd6, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
    #1 check("split_rdy4", {31'b0, rdy_a}, 32'h1);
    check("split_rdy6", {31'b0, rdy_b}, 32'h0);
    check("split_data4", rdata_a, 32'h88);

    // Issue to r0 and duplicate issue
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("iss_r0_rdy", {31'b0, rdy_a}, 32'h1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    tick();
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    #1 check("dup_iss_pending", {31'b0, rdy_a}, 32'h0);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    #1 check("dup_iss_cleared", {31'b0, rdy_a}, 32'h1);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
      check_ports("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

32-entry × 32-bit MIPS general-purpose register file with two combinational read ports, one synchronous write port and an integrated scoreboard of pending-write bits. It sits in the decode stage and supplies the 32 register words that each read port's 32-to-1 selection consumes. Writeback updates it, and issue logic marks destination registers pending. Read ports bypass a same-cycle write so decode always sees the newest value.

## Interface
- `WIDTH`, 32, data word width
- `DEPTH`, 32, number of registers; address width is 5 and fixed
- `clk` input 1: single clock; all state updates on its rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `raddr_a` input 5: read port A address
- `raddr_b` input 5: read port B address
- `rdata_a` output 32: read port A data (combinational)
- `rdata_b` output 32: read port B data (combinational)
- `rdy_a` output 1: register at `raddr_a` has no outstanding producer
- `rdy_b` output 1: register at `raddr_b` has no outstanding producer
- `we` input 1: writeback write enable
- `waddr` input 5: writeback destination
- `wdata` input 32: writeback data
- `iss` input 1: an instruction is issuing with a register destination
- `iss_dst` input 5: destination of the issuing instruction

## Operation
- Storage: `regs[0..31]`, each 32 bits. `pend[0..31]`, each 1 bit.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - `pend[0]` is never set.
  - `rdy` for address 0 is always 1.
- Write: on a `clk` rising edge with `we=1` and `waddr≠0`, `regs[waddr] <= wdata` and `pend[waddr] <= 0`. The pend clear is overridden by the issue rule below.
- Issue: on a `clk` rising edge with `iss=1` and `iss_dst≠0`, `pend[iss_dst] <= 1`.
- Simultaneous write and issue to the same nonzero register in one cycle:
  - Data is written.
  - `pend` ends at 1, because the set takes priority.
- Simultaneous write and issue to different registers: both take effect independently.
- Read port X (A or B), evaluated combinationally in this order:
  - If `raddr_x=0`: `rdata_x=0`, `rdy_x=1`.
  - Else if `we=1` and `waddr=raddr_x`: `rdata_x=wdata` and `rdy_x=1` (write-through bypass).
  - Else: `rdata_x=regs[raddr_x]`, `rdy_x=!pend[raddr_x]`.
- Issue has no effect on same-cycle read outputs. A register issued in cycle N reads `rdy=0` starting in cycle N+1.
- Both read ports are fully independent and may use the same address.
- Duplicate issue to an already pending register: `pend` stays 1. It is not a counter; one write clears it.
- Write to a register that is not pending: legal. Data updates and `pend` stays 0.

## Timing
- Reset (`rst_n=0`, asserted asynchronously at any time, including mid-write):
  - All `regs` clear to 0 and all `pend` clear to 0 immediately, without waiting for `clk`.
  - `rdata_a` and `rdata_b` read 0 (unless bypassing a live `wdata`).
  - `rdy_a` and `rdy_b` read 1.
- While `rst_n=0`, no edge updates state.
- Deassertion is synchronized externally. The first edge with `rst_n=1` performs normal updates.
- Read latency is 0 cycles (combinational from address and write inputs).
- Write latency: visible on the read port the same cycle via bypass, and from `regs` starting the next cycle.
- Scoreboard: set is visible the cycle after `iss`. Clear is visible the same cycle as `we` (via bypass) and persists thereafter.
- No handshake: `we` and `iss` are single-cycle strobes, one event each per cycle.

## Test plan
- Reset and zero register:
  - Stimulus: assert `rst_n=0` mid-cycle after writing `regs[5]=0xDEADBEEF`.
  - Required: `rdata_a` with `raddr_a=5` reads 0 immediately.
  - Stimulus: after release, write `waddr=0`, `wdata=0x12345678`.
  - Required: `raddr_a=0` reads 0 with `rdy_a=1`.
- Write then read:
  - Stimulus: write `regs[7]=0xA5A5A5A5`, `regs[31]=0x0000FFFF`.
  - Required: the next cycle, A=7 and B=31 return those values. Both ports set to 7 both return `0xA5A5A5A5`.
- Bypass:
  - Stimulus: with `regs[9]=0x11111111`, drive `we=1`, `waddr=9`, `wdata=0x22222222`, `raddr_a=9`.
  - Required: `rdata_a=0x22222222` in the same cycle, before the edge.
- Scoreboard set and clear:
  - Stimulus: `iss=1`, `iss_dst=12` at cycle N.
  - Required: cycle N `rdy_a(12)=1`; cycle N+1 `rdy_a=0`.
  - Stimulus: `we=1`, `waddr=12` at cycle N+3.
  - Required: `rdy_a=1` in N+3 and after.
- Write/issue collision:
  - Stimulus: same cycle `we=1`, `waddr=4`, `wdata=0x77` and `iss=1`, `iss_dst=4`.
  - Required: next cycle `rdata(4)=0x77`, `rdy=0`.
  - Stimulus: same cycle `we` to 4 and `iss` to 6.
  - Required: next cycle `rdy(4)=1`, `rdy(6)=0`.
- Issue to r0 and duplicate issue:
  - Stimulus: `iss_dst=0`.
  - Required: `rdy(0)` stays 1.
  - Stimulus: issue to 3 twice, then write 3 once.
  - Required: `rdy(3)=1`.
